// File: rtl/hesap_pkg.sv
// Shared definitions for the divider result to BCD converter: state encoding
// and the fixed widths of the integer part and its decimal form.
package hesap_pkg;

  localparam logic [1:0] BOS   = 2'd0;
  localparam logic [1:0] TAM   = 2'd1;
  localparam logic [1:0] KESIR = 2'd2;
  localparam logic [1:0] BITTI = 2'd3;

  localparam int TAM_BIT      = 32;
  localparam int BCD_HANE     = 10;
  localparam int BCD_GENISLIK = 40;

endpackage

// File: rtl/bcd_arti3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_arti3 (
  input  logic [3:0] hane,
  output logic [3:0] duzeltilmis
);

  assign duzeltilmis = (hane >= 4'd5) ? hane + 4'd3 : hane;

endmodule

// File: rtl/sonuc_bcd_donusturucu.sv
// Converts the divider's 32.32 fixed-point result into 10 integer BCD digits
// (double-dabble, one bit per clock) and KESIR_HANE truncated fraction digits.
module sonuc_bcd_donusturucu
  import hesap_pkg::*;
#(
  parameter int KESIR_HANE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             sonuc,
  input  logic                    tasma,
  input  logic                    giris_gecerli,
  output logic                    mesgul,
  output logic [BCD_GENISLIK-1:0] tam_bcd,
  output logic [4*KESIR_HANE-1:0] kesir_bcd,
  output logic                    hata,
  output logic                    cikis_gecerli
);

  logic [1:0]                durum;
  logic [TAM_BIT-1:0]        tam_sr;
  logic [31:0]               kesir_r;
  logic [BCD_GENISLIK-1:0]   bcd_r;
  logic [BCD_GENISLIK-1:0]   bcd_duz;
  logic [4*KESIR_HANE-1:0]   kesir_hane_r;
  logic [4*KESIR_HANE-1:0]   kesir_hane_sonraki;
  logic                      tasma_r;
  logic [5:0]                sayac;
  logic [35:0]               carpim;

  // Fraction digit extraction: the integer part of fraction*10 is the next digit.
  function automatic logic [35:0] carpi10(input logic [31:0] x);
    logic [35:0] genis;
    genis = {4'd0, x};
    return (genis << 3) + (genis << 1);
  endfunction

  genvar g;
  generate
    for (g = 0; g < BCD_HANE; g++) begin : g_arti3
      bcd_arti3 u_arti3 (
        .hane        (bcd_r[4*g +: 4]),
        .duzeltilmis (bcd_duz[4*g +: 4])
      );
    end
  endgenerate

  assign carpim = carpi10(kesir_r);
  assign mesgul = (durum != BOS);

  always_comb begin
    kesir_hane_sonraki      = kesir_hane_r << 4;
    kesir_hane_sonraki[3:0] = carpim[35:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum         <= BOS;
      tam_sr        <= '0;
      kesir_r       <= '0;
      bcd_r         <= '0;
      kesir_hane_r  <= '0;
      tasma_r       <= 1'b0;
      sayac         <= '0;
      tam_bcd       <= '0;
      kesir_bcd     <= '0;
      hata          <= 1'b0;
      cikis_gecerli <= 1'b0;
    end else begin
      cikis_gecerli <= 1'b0;
      case (durum)
        BOS: begin
          if (giris_gecerli) begin
            tam_sr       <= sonuc[63:32];
            kesir_r      <= sonuc[31:0];
            tasma_r      <= tasma;
            bcd_r        <= '0;
            kesir_hane_r <= '0;
            sayac        <= '0;
            durum        <= TAM;
          end
        end
        TAM: begin
          bcd_r  <= {bcd_duz[BCD_GENISLIK-2:0], tam_sr[TAM_BIT-1]};
          tam_sr <= {tam_sr[TAM_BIT-2:0], 1'b0};
          if (sayac == 6'(TAM_BIT - 1)) begin
            sayac <= '0;
            durum <= KESIR;
          end else begin
            sayac <= sayac + 6'd1;
          end
        end
        KESIR: begin
          kesir_hane_r <= kesir_hane_sonraki;
          kesir_r      <= carpim[31:0];
          if (sayac == 6'(KESIR_HANE - 1)) begin
            sayac <= '0;
            durum <= BITTI;
          end else begin
            sayac <= sayac + 6'd1;
          end
        end
        default: begin
          tam_bcd       <= bcd_r;
          kesir_bcd     <= kesir_hane_r;
          hata          <= tasma_r;
          cikis_gecerli <= 1'b1;
          durum         <= BOS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonuc_bcd_donusturucu.sv
// Randomized scoreboard bench for sonuc_bcd_donusturucu; expected digits come
// from plain decimal arithmetic on the 32.32 value.
module tb_sonuc_bcd_donusturucu;

  localparam int K = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   sonuc;
  logic          tasma;
  logic          giris_gecerli;
  logic          mesgul;
  logic [39:0]   tam_bcd;
  logic [4*K-1:0] kesir_bcd;
  logic          hata;
  logic          cikis_gecerli;

  logic [63:0]   sonuc9;
  logic          tasma9;
  logic          giris9;
  logic          mesgul9;
  logic [39:0]   tam_bcd9;
  logic [35:0]   kesir_bcd9;
  logic          hata9;
  logic          cikis9;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [39:0]    tam;
    logic [4*K-1:0] kes;
    logic           hata;
    int             cyc;
  } beklenen_t;

  beklenen_t sb[$];

  sonuc_bcd_donusturucu #(.KESIR_HANE(K)) dut (
    .clk           (clk),
    .rst           (rst),
    .sonuc         (sonuc),
    .tasma         (tasma),
    .giris_gecerli (giris_gecerli),
    .mesgul        (mesgul),
    .tam_bcd       (tam_bcd),
    .kesir_bcd     (kesir_bcd),
    .hata          (hata),
    .cikis_gecerli (cikis_gecerli)
  );

  sonuc_bcd_donusturucu #(.KESIR_HANE(9)) dut9 (
    .clk           (clk),
    .rst           (rst),
    .sonuc         (sonuc9),
    .tasma         (tasma9),
    .giris_gecerli (giris9),
    .mesgul        (mesgul9),
    .tam_bcd       (tam_bcd9),
    .kesir_bcd     (kesir_bcd9),
    .hata          (hata9),
    .cikis_gecerli (cikis9)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Lowest n decimal digits of x, packed as BCD with the least significant digit in [3:0].
  function automatic logic [63:0] ondalik(input longint unsigned x, input int n);
    logic [63:0] r;
    longint unsigned v;
    r = '0;
    v = x;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // floor(frac / 2^32 * 10^n): the truncated n-digit decimal fraction.
  function automatic longint unsigned kesir_olcekli(input logic [31:0] f, input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return ({32'd0, f} * p) >> 32;
  endfunction

  task automatic chk(input string ad, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", ad, act, exp);
    end
  endtask

  task automatic beklenen_ekle(input logic [63:0] s, input logic t, input int c);
    beklenen_t e;
    logic [63:0] k;
    e.tam  = ondalik({32'd0, s[63:32]}, 10)[39:0];
    k      = ondalik(kesir_olcekli(s[31:0], K), K);
    e.kes  = k[4*K-1:0];
    e.hata = t;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic bosta_bekle();
    int n = 0;
    while (mesgul && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(mesgul), 64'd0);
  endtask

  // Called at a negedge; one-cycle request, then scramble inputs to prove they are frozen.
  task automatic gonder(input logic [63:0] s, input logic t);
    bosta_bekle();
    giris_gecerli = 1'b1;
    sonuc         = s;
    tasma         = t;
    beklenen_ekle(s, t, cyc + 1 + 33 + K);
    @(negedge clk);
    giris_gecerli = 1'b0;
    sonuc         = {$urandom, $urandom};
    tasma         = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (!rst && cikis_gecerli) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        beklenen_t e;
        e = sb.pop_front();
        chk("tam_bcd", 64'(tam_bcd), 64'(e.tam));
        chk("kesir_bcd", 64'(kesir_bcd), 64'(e.kes));
        chk("hata", 64'(hata), 64'(e.hata));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    int c0;
    int e1;
    logic [63:0] a;
    logic [63:0] b;

    rst           = 1'b1;
    giris_gecerli = 1'b0;
    sonuc         = '0;
    tasma         = 1'b0;
    giris9        = 1'b0;
    sonuc9        = '0;
    tasma9        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tam", 64'(tam_bcd), 64'd0);
    chk("rst_kesir", 64'(kesir_bcd), 64'd0);
    chk("rst_hata", 64'(hata), 64'd0);
    chk("rst_mesgul", 64'(mesgul), 64'd0);
    chk("rst_pulse", 64'(cikis_gecerli), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    gonder(64'h00000003_80000000, 1'b0);
    gonder(64'h00000000_55555555, 1'b0);
    gonder(64'hFFFFFFFF_FFFFFFFF, 1'b1);
    gonder(64'h00000000_00000000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      gonder({$urandom, $urandom}, 1'($urandom));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    // Held valid: operands change mid-conversion, recapture right after the pulse.
    bosta_bekle();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    giris_gecerli = 1'b1;
    sonuc         = a;
    tasma         = 1'b0;
    e1            = cyc + 1 + 33 + K;
    beklenen_ekle(a, 1'b0, e1);
    repeat (10) @(negedge clk);
    sonuc = b;
    tasma = 1'b1;
    beklenen_ekle(b, 1'b1, e1 + 34 + K);
    n = 0;
    while (!cikis_gecerli && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("held_pulse_timeout", 64'd0, 64'd1);
    @(negedge clk);
    giris_gecerli = 1'b0;
    chk("held_recapture", 64'(mesgul), 64'd1);
    bosta_bekle();

    // Reset in the middle of TAM aborts with no pulse.
    gonder(64'h12345678_9ABCDEF0, 1'b1);
    void'(sb.pop_back());
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tam", 64'(tam_bcd), 64'd0);
    chk("abort_kesir", 64'(kesir_bcd), 64'd0);
    chk("abort_hata", 64'(hata), 64'd0);
    chk("abort_mesgul", 64'(mesgul), 64'd0);
    chk("abort_pulse", 64'(cikis_gecerli), 64'd0);
    repeat (50) @(negedge clk);
    gonder(64'h00000007_40000000, 1'b0);

    // Nine fraction digits: 2^-32 truncates to zero.
    c0     = cyc;
    giris9 = 1'b1;
    sonuc9 = 64'h0000000A_00000001;
    @(negedge clk);
    giris9 = 1'b0;
    sonuc9 = 64'hFFFFFFFF_FFFFFFFF;
    n = 0;
    while (!cikis9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("k9_latency", 64'(cyc - c0), 64'd43);
    chk("k9_tam", 64'(tam_bcd9), 64'h10);
    chk("k9_kesir", 64'(kesir_bcd9), 64'd0);
    chk("k9_hata", 64'(hata9), 64'd0);

    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
